// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive path and the transmitter.
// Defining UART_RX_PARITY_EN adds the PARITY state for even-parity frames.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } uart_rx_state_t;

   function automatic int clks_per_bit(input int clkHz, input int baud);
      return clkHz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head output that reads 0 while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_q,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPop;
   logic             w_doPush;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == (AW+1)'(DEPTH));
   assign o_count  = r_count;
   assign w_doPop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_doPush = i_push && (!o_full || w_doPop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
      end
   end

   always_ff @(posedge clock) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_data;
   end

   assign o_q = o_empty ? '0 : r_mem[r_rdPtr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a show-ahead FIFO
// with sticky overrun and framing-error flags.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          uart_rx,
   input  logic                          rd_en,
   input  logic                          err_clear,
   output logic [UART_DATA_BITS-1:0]     rx_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          overrun,
   output logic                          frame_err
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

   uart_rx_state_t              r_state;
   logic                        r_sync1;
   logic                        r_rxs;
   logic [CW-1:0]               r_cnt;
   logic [2:0]                  r_idx;
   logic [UART_DATA_BITS-1:0]   r_shift;
   logic                        w_bitEnd;
   logic                        w_parBad;
   logic                        w_push;
   logic                        w_frameBad;
   logic                        w_drop;
   logic                        w_full;
   logic                        w_empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_rxs   <= 1'b1;
      end else begin
         r_sync1 <= uart_rx;
         r_rxs   <= r_sync1;
      end
   end

   assign w_bitEnd = (r_cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
   logic r_parErr;
   assign w_parBad = r_parErr;
`else
   assign w_parBad = 1'b0;
`endif

   // The stop-bit sample decides the frame: push it, or flag and discard it.
   assign w_push     = (r_state == STOP) && w_bitEnd && r_rxs && !w_parBad;
   assign w_frameBad = (r_state == STOP) && w_bitEnd && (!r_rxs || w_parBad);
   assign w_drop     = w_push && w_full && !rd_en;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
         r_parErr <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (!r_rxs) r_state <= START;
            end
            START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= r_rxs ? IDLE : DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (w_bitEnd) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rxs, r_shift[UART_DATA_BITS-1:1]};
                  if (r_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_bitEnd) begin
                  r_cnt    <= '0;
                  r_parErr <= (r_rxs != ^r_shift);
                  r_state  <= STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_bitEnd) begin
                  r_cnt   <= '0;
                  r_state <= r_rxs ? IDLE : BREAK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            BREAK: begin
               if (r_rxs) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Setting wins over clearing so an error in the clear cycle is not lost.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (err_clear)  overrun   <= 1'b0;
         if (w_drop)     overrun   <= 1'b1;
         if (err_clear)  frame_err <= 1'b0;
         if (w_frameBad) frame_err <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (r_shift),
      .i_pop   (rd_en),
      .o_q     (rx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (rx_count)
   );

   assign rx_valid = !w_empty;

endmodule
